// File: rtl/ridecore_mem_sys_pkg.sv
// Shared constants and helpers for the RIDECORE memory subsystem.
package ridecore_mem_sys_pkg;

  localparam int ADDR_LEN_D    = 32;
  localparam int DATA_LEN_D    = 32;
  localparam int INSN_LEN_D    = 32;
  localparam int FETCH_WIDTH_D = 4;
  localparam int DMEM_LAT_MIN  = 0;
  localparam int DMEM_LAT_MAX  = 4;

  // Data request kind, decoded from the single write strobe
  typedef enum logic [0:0] {
    DMEM_LOAD  = 1'b0,
    DMEM_STORE = 1'b1
  } dmem_op_e;

  // Legal range check for the data read latency
  function automatic bit dmem_lat_legal(input int lat);
    return (lat >= DMEM_LAT_MIN) && (lat <= DMEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/ridecore_mem_sys_if.sv
// Fetch and data bus between the pipeline (master) and the memory subsystem (slave).
interface ridecore_mem_sys_if
  import ridecore_mem_sys_pkg::*;
#(
  parameter int ADDR_LEN    = ADDR_LEN_D,
  parameter int DATA_LEN    = DATA_LEN_D,
  parameter int INSN_LEN    = INSN_LEN_D,
  parameter int FETCH_WIDTH = FETCH_WIDTH_D
);
  logic [ADDR_LEN-1:0]             imem_addr;
  logic [FETCH_WIDTH*INSN_LEN-1:0] imem_data;
  logic                            dmem_req_valid;
  logic                            dmem_req_ready;
  logic                            dmem_req_write;
  logic [ADDR_LEN-1:0]             dmem_req_addr;
  logic [DATA_LEN-1:0]             dmem_req_wdata;
  logic [DATA_LEN/8-1:0]           dmem_req_be;
  logic                            dmem_resp_valid;
  logic [DATA_LEN-1:0]             dmem_resp_data;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_req_valid,
    input  dmem_req_ready,
    output dmem_req_write,
    output dmem_req_addr,
    output dmem_req_wdata,
    output dmem_req_be,
    input  dmem_resp_valid,
    input  dmem_resp_data
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_req_valid,
    output dmem_req_ready,
    input  dmem_req_write,
    input  dmem_req_addr,
    input  dmem_req_wdata,
    input  dmem_req_be,
    output dmem_resp_valid,
    output dmem_resp_data
  );
endinterface

// File: rtl/ridecore_dmem_pipe.sv
// LAT-stage valid+data delay line for load responses. Data only advances with
// a valid bit, so the last stage holds the most recent load result.
// LAT = 0 degenerates to plain wires.
module ridecore_dmem_pipe #(
  parameter int LAT   = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (LAT == 0) begin : g_bypass
      logic w_unused_clk;
      assign w_unused_clk = clk ^ rst;
      assign o_valid      = i_valid;
      assign o_data       = i_data;
    end else begin : g_pipe
      for (genvar s = 0; s < LAT; s++) begin : g_stage
        logic             r_vld;
        logic [WIDTH-1:0] r_dat;
        logic             w_pv;
        logic [WIDTH-1:0] w_pd;

        if (s == 0) begin : g_head
          assign w_pv = i_valid;
          assign w_pd = i_data;
        end else begin : g_link
          assign w_pv = g_stage[s-1].r_vld;
          assign w_pd = g_stage[s-1].r_dat;
        end

        // Shift one stage; reset discards anything in flight
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
          end else begin
            r_vld <= w_pv;
            if (w_pv) begin
              r_dat <= w_pd;
            end
          end
        end
      end

      assign o_valid = g_stage[LAT-1].r_vld;
      assign o_data  = g_stage[LAT-1].r_dat;
    end
  endgenerate

endmodule

// File: rtl/ridecore_mem_sys.sv
// RIDECORE memory subsystem: wide combinational instruction fetch, byte-enabled
// data port with configurable load latency, and a stretched pipeline reset.
module ridecore_mem_sys
  import ridecore_mem_sys_pkg::*;
#(
  parameter int ADDR_LEN    = ADDR_LEN_D,
  parameter int DATA_LEN    = DATA_LEN_D,
  parameter int INSN_LEN    = INSN_LEN_D,
  parameter int FETCH_WIDTH = FETCH_WIDTH_D,
  parameter int IMEM_DEPTH  = 4096,
  parameter int DMEM_DEPTH  = 4096,
  parameter int DMEM_LAT    = 2,
  parameter int RST_HOLD    = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               core_reset,
  ridecore_mem_sys_if.slave  bus
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int BYTES   = DATA_LEN / 8;
  localparam int BOFF    = $clog2(BYTES);

  generate
    if (!dmem_lat_legal(DMEM_LAT)) begin : g_bad_lat
      $error("ridecore_mem_sys: DMEM_LAT out of range 0..4");
    end
  endgenerate

  // Arrays are never reset; contents come from simulation preload or stores.
  logic [INSN_LEN-1:0] r_imem [IMEM_DEPTH];
  logic [DATA_LEN-1:0] r_dmem [DMEM_DEPTH];

  logic [3:0] r_hold_cnt;
  logic       r_core_reset;

  // Hold core_reset for RST_HOLD edges after rst falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt   <= 4'(RST_HOLD);
      r_core_reset <= 1'b1;
    end else if (r_hold_cnt != 4'd0) begin
      r_hold_cnt   <= r_hold_cnt - 4'd1;
      r_core_reset <= (r_hold_cnt != 4'd1);
    end else begin
      r_hold_cnt   <= r_hold_cnt;
      r_core_reset <= 1'b0;
    end
  end

  assign core_reset = r_core_reset;

  // Fetch: word index aligned down to a whole block, so a block never wraps.
  logic [IMEM_AW-1:0] w_iword;
  logic [IMEM_AW-1:0] w_ibase;
  assign w_iword = bus.imem_addr[IMEM_AW+1:2];
  assign w_ibase = w_iword & ~IMEM_AW'(FETCH_WIDTH - 1);

  generate
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
      assign bus.imem_data[k*INSN_LEN +: INSN_LEN] = r_imem[w_ibase + IMEM_AW'(k)];
    end
  endgenerate

  // Data port: the only backpressure is the stretched reset.
  dmem_op_e            w_op;
  logic                w_ready;
  logic                w_accept;
  logic                w_store;
  logic                w_load;
  logic [DMEM_AW-1:0]  w_didx;
  logic [DATA_LEN-1:0] w_rdata;
  logic                w_unused;

  assign w_op     = dmem_op_e'(bus.dmem_req_write);
  assign w_ready  = ~r_core_reset;
  assign w_accept = bus.dmem_req_valid & w_ready;
  assign w_store  = w_accept & (w_op == DMEM_STORE);
  assign w_load   = w_accept & (w_op == DMEM_LOAD);
  assign w_didx   = bus.dmem_req_addr[DMEM_AW+BOFF-1:BOFF];
  assign w_rdata  = r_dmem[w_didx];
  assign w_unused = ^{bus.imem_addr, bus.dmem_req_addr};

  assign bus.dmem_req_ready = w_ready;

  // Byte-enabled store on the accepting edge; be = 0 writes nothing
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.dmem_req_be[b]) begin
          r_dmem[w_didx][b*8 +: 8] <= bus.dmem_req_wdata[b*8 +: 8];
        end
      end
    end
  end

  ridecore_dmem_pipe #(
    .LAT   (DMEM_LAT),
    .WIDTH (DATA_LEN)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_load),
    .i_data  (w_rdata),
    .o_valid (bus.dmem_resp_valid),
    .o_data  (bus.dmem_resp_data)
  );

endmodule

// File: doc/ridecore_mem_sys.md
# ridecore_mem_sys

Parametrised memory subsystem for the RIDECORE core. It provides a wide instruction fetch port, with FETCH_WIDTH instructions per fetch. It also provides a byte-enabled data port with configurable read latency and a valid/ready handshake, plus a stretched core reset output for the pipeline. It sits beside `pipeline` inside the core top and replaces the fixed single-cycle memory model. DMEM_LAT = 0 reproduces the old combinational data-read behaviour.

## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data word width (multiple of 8)
- INSN_LEN, 32, instruction width
- FETCH_WIDTH, 4, instructions returned per fetch (power of 2, 1..8)
- IMEM_DEPTH, 4096, instruction memory depth in INSN_LEN words (power of 2)
- DMEM_DEPTH, 4096, data memory depth in DATA_LEN words (power of 2)
- DMEM_LAT, 2, data read latency in cycles (0..4)
- RST_HOLD, 4, cycles core_reset stays high after rst falls (1..15)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- core_reset  out  1  reset to pipeline
- imem_addr  in  ADDR_LEN  byte fetch address
- imem_data  out  FETCH_WIDTH*INSN_LEN  fetch block, lowest address in bits [INSN_LEN-1:0]
- dmem_req_valid  in  1  request present
- dmem_req_ready  out  1  request accepted when valid & ready
- dmem_req_write  in  1  1 = store, 0 = load
- dmem_req_addr  in  ADDR_LEN  byte address
- dmem_req_wdata  in  DATA_LEN  store data
- dmem_req_be  in  DATA_LEN/8  store byte enables
- dmem_resp_valid  out  1  load data valid (one-cycle pulse per load)
- dmem_resp_data  out  DATA_LEN  load data

## Operation
- Reset
  - rst high resets core_reset to 1 and the hold counter to RST_HOLD.
  - It clears all DMEM pipeline valid bits.
  - dmem_req_ready = 0, dmem_resp_valid = 0, dmem_resp_data = 0.
  - Memory array contents are not reset. They are initialised only by simulation preload.
- Reset stretch
  - After rst falls, the counter decrements on each rising edge.
  - core_reset goes low on the edge where the counter reaches 0.
- Fetch
  - Word index = imem_addr >> 2, aligned down to a multiple of FETCH_WIDTH, modulo IMEM_DEPTH.
  - Read is combinational, valid in every cycle including reset.
  - A block never straddles the top of memory, because alignment guarantees this.
- Data accepted
  - dmem_req_ready = ~core_reset; no other backpressure.
  - At most one request per cycle.
  - Word index = dmem_req_addr >> log2(DATA_LEN/8), modulo DMEM_DEPTH.
  - Low address bits are ignored; there is no misalignment trap.
- Store
  - The array is written on the accepting edge, only the bytes whose dmem_req_be bit is set.
  - be = 0 is legal and writes nothing.
  - No response is generated.
- Load
  - The array is read at the accepting edge, so it sees every store accepted on earlier edges.
  - Data travels through a DMEM_LAT-stage valid/data shift register.
  - The response is presented DMEM_LAT cycles later; loads complete in order and are never dropped.
  - dmem_resp_data holds its last value when dmem_resp_valid = 0.
- DMEM_LAT = 0 (legacy mode)
  - dmem_resp_valid = req_valid & req_ready & ~req_write, combinationally.
  - dmem_resp_data is a combinational array read.
- Reset mid-operation
  - In-flight loads are discarded and no response is produced for them.
  - A store accepted on the same edge that rst rises is not guaranteed; the bench must not rely on it.

## Timing
- Fetch latency 0 cycles.
- Load latency DMEM_LAT cycles, 0 in legacy mode.
- Throughput one request per cycle, any read/write mix.
- Store-then-load to the same address on consecutive cycles: the load returns the new data.
- core_reset low exactly RST_HOLD rising edges after rst deasserts.

## Structure
- Shared header (alongside `define.v`/`constants.vh`):
  - ADDR_LEN/DATA_LEN/INSN_LEN defaults
  - FETCH_WIDTH
  - the DMEM_LAT legal range check
- Sub-module `ridecore_dmem_pipe`:
  - parametrised DMEM_LAT-stage valid+data delay line with asynchronous clear
  - pass-through wires when DMEM_LAT = 0
- Arrays, byte-enable write and the reset counter live in the top.

## Test plan
- Reset stretch: rst high 3 cycles, then low.
  - core_reset high through reset and low after exactly 4 edges (RST_HOLD = 4).
  - dmem_req_ready rises in the same cycle that core_reset falls.
- Fetch: preload IMEM words 0..7 with 0x1000+i, drive imem_addr = 0x14.
  - imem_data holds words 4..7, with 0x1004 in the low lane.
  - Drive imem_addr = IMEM_DEPTH*4 + 0x4: block 0..3 (wrap).
- Byte-enable store/load: preload word 0x40 = 0x00000000, store 0xAABBCCDD with be = 0b0101, then load 0x40.
  - resp_valid after 2 cycles, resp_data = 0x00BB00DD.
- Back-to-back: loads to addresses A, B, C on 3 consecutive cycles (DMEM_LAT = 2).
  - 3 consecutive resp_valid pulses, in order, with the correct data.
  - Store 0x5 to A followed next cycle by a load of A returns 0x5.
- Reset mid-flight: issue a load, assert rst one cycle later.
  - No resp_valid during reset or after it; memory contents are retained.
- Legacy mode: DMEM_LAT = 0 build, load of a preloaded word 0x1234.
  - resp_valid and resp_data = 0x1234 in the same cycle as the request.
